board_engine: RTL and testbench
===============================

# board_engine

Game-play engine for the 2×2 sliding-tile puzzle and the consumer of the 12-bit board produced by the board generator. Latches the chosen board when the player confirms, then applies blank-tile moves from debounced buttons and counts moves. Detects the solved board and drives the shared `game_status` bus that the generator and display logic follow.

## Interface
- No parameters. Constants come from `game_pkg`.
- `clk_d` in 1: game clock, the same divided clock the generator uses.
- `rst_n` in 1: reset, synchronous, active-low.
- `board_in` in 12: generator output. Position p (0..3) occupies bits [11-3p : 9-3p]. Positions are p0 top-left, p1 top-right, p2 bottom-left, p3 bottom-right. Tile value 3'd0 is the blank.
- `start` in 1: single-cycle pulse. Confirm the board in CHOSE_BOARD, or return to CHOSE_BOARD from WINNED.
- `give_up` in 1: single-cycle pulse. Abandon the game from GAMING.
- `move_valid` in 1: single-cycle pulse qualifying `move_dir`.
- `move_dir` in 2: direction the blank moves. 00 up, 01 down, 10 left, 11 right.
- `game_status` out 2: 00 CHOSE_BOARD, 01 GAMING, 10 GAME_INITIAL, 11 WINNED.
- `board` out 12: current board, same field layout as `board_in`.
- `blank_pos` out 2: position index of the blank tile.
- `move_cnt` out 10: number of legal moves, saturating at 999.
- `move_err` out 1: one-cycle pulse when an illegal move is requested.

## Operation
- FSM states are encoded exactly as the `game_status` values. All outputs are registered.
- **CHOSE_BOARD**
  - `board` mirrors nothing; it holds its last value.
  - On `start`: `board` ← `board_in`, sampled while the status is still 00, because the generator forces identity once the status leaves 00.
  - `move_cnt` ← 0, `blank_pos` ← index of the 3'd0 field, next state GAME_INITIAL.
  - If `board_in` has no 3'd0 field, `blank_pos` ← 0. The input is not further validated.
- **GAME_INITIAL** lasts exactly one cycle.
  - If `board` == SOLVED (12'b000_001_010_011), next state is WINNED.
  - Otherwise, next state is GAMING.
- **GAMING**, inputs in priority order:
  - `give_up` → CHOSE_BOARD. Board and count are held. Any coincident move is dropped.
  - `move_valid` with a legal direction: swap the blank with its neighbour and update `blank_pos`. Increment `move_cnt` if it is below 999.
  - Legality, with row = p[1] and col = p[0]:
    - up needs row=1; target p-2.
    - down needs row=0; target p+2.
    - left needs col=1; target p-1.
    - right needs col=0; target p+1.
  - Illegal move: `move_err` = 1 for one cycle. Board, count and position are unchanged.
  - Win check is on the next board value. If it equals SOLVED, the state goes to WINNED on the same edge the board is written.
- **WINNED**
  - `board` and `move_cnt` are frozen. Moves and `give_up` are ignored.
  - `start` → CHOSE_BOARD.
- `start` is ignored in GAMING and GAME_INITIAL. Move inputs are ignored outside GAMING.
- Only 12 of the 24 permutations are reachable from the solved board. Unsolvable boards stay in GAMING until `give_up`; no detection is required.

## Timing
- Reset (`rst_n`=0 at an edge) gives:
  - `game_status`=00, `board`=12'b000_001_010_011, `blank_pos`=0, `move_cnt`=0, `move_err`=0.
- Reset mid-game takes effect at the next edge and overrides all other inputs.
- `start` in CHOSE_BOARD: the board is latched and the status reads 10 one cycle later. The status reads 01 or 11 two cycles after `start`.
- Move: `board`, `blank_pos`, `move_cnt` and, when solved, `game_status` update one cycle after `move_valid`.
- `move_err` is high for the cycle following the illegal request.
- Back-to-back moves on consecutive cycles are each applied. A move in the cycle that causes WINNED is the last one accepted.

## Structure
- `game_pkg` holds:
  - status localparams CHOSE_BOARD, GAMING, GAME_INITIAL, WINNED;
  - SOLVED_BOARD;
  - direction codes DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT;
  - MOVE_CNT_MAX = 999.
- The generator moves to the same package.
- One combinational sub-module, `tile_mover`, computes from `board`, `blank_pos` and `move_dir`:
  - `legal`;
  - `next_board`;
  - `next_blank`.
- The FSM, counter and error pulse live in `board_engine`.

## Test plan
1. **Reset and load.** Release reset, confirm identity outputs. Set `board_in`=12'b001_000_010_011 and pulse `start`.
   - Required: status 10, then 01; `board` latched; `blank_pos`=1.
2. **Winning move.** From scenario 1, move left.
   - Required: `board`=12'b000_001_010_011, `blank_pos`=0, `move_cnt`=1, status 11 on the same edge.
   - Then `start` → status 00.
3. **Illegal move.** Load 12'b000_001_011_010, then move up.
   - Required: `move_err` high for 1 cycle; board, count and `blank_pos` unchanged; status 01.
   - Then move right: `board`=12'b001_000_011_010, `move_cnt`=1.
4. **Already solved.** Load 12'b000_001_010_011.
   - Required: status 10 then 11 directly, `move_cnt`=0.
5. **Give-up priority.** In GAMING, pulse `give_up` and `move_valid` together.
   - Required: status 00, board unchanged, count unchanged.
6. **Saturation and reset.**
   - Alternate right/left 1005 times on an unsolved board: `move_cnt` stops at 999.
   - Assert `rst_n`=0 mid-game: all outputs return to reset values at the next edge.

Source files
------------

// File: rtl/game_pkg.sv
// Shared constants and board-field helpers for the 2x2 sliding-tile game.
// Position p occupies board bits [11-3p : 9-3p]; tile 3'd0 is the blank.
package game_pkg;

  typedef enum logic [1:0] {
    CHOSE_BOARD  = 2'b00,
    GAMING       = 2'b01,
    GAME_INITIAL = 2'b10,
    WINNED       = 2'b11
  } status_e;

  localparam logic [11:0] SOLVED_BOARD = 12'b000_001_010_011;
  localparam logic [2:0]  BLANK_TILE   = 3'd0;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  localparam logic [9:0] MOVE_CNT_MAX = 10'd999;

  function automatic logic [2:0] tile_at(input logic [11:0] b, input logic [1:0] p);
    case (p)
      2'd0:    return b[11:9];
      2'd1:    return b[8:6];
      2'd2:    return b[5:3];
      default: return b[2:0];
    endcase
  endfunction

  function automatic logic [11:0] set_tile(input logic [11:0] b, input logic [1:0] p,
                                           input logic [2:0] t);
    logic [11:0] r;
    r = b;
    case (p)
      2'd0:    r[11:9] = t;
      2'd1:    r[8:6]  = t;
      2'd2:    r[5:3]  = t;
      default: r[2:0]  = t;
    endcase
    return r;
  endfunction

  // Lowest position holding the blank; 0 when the board has none.
  function automatic logic [1:0] find_blank(input logic [11:0] b);
    logic [1:0] pos;
    pos = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (tile_at(b, 2'(i)) == BLANK_TILE) pos = 2'(i);
    return pos;
  endfunction

endpackage

// File: rtl/board_engine_if.sv
// Player-side bus of the game engine: board load, controls, moves and status.
interface board_engine_if;
  logic [11:0] board_in;
  logic        start;
  logic        give_up;
  logic        move_valid;
  logic [1:0]  move_dir;
  logic [1:0]  game_status;
  logic [11:0] board;
  logic [1:0]  blank_pos;
  logic [9:0]  move_cnt;
  logic        move_err;

  modport master (
    output board_in, start, give_up, move_valid, move_dir,
    input  game_status, board, blank_pos, move_cnt, move_err
  );

  modport slave (
    input  board_in, start, give_up, move_valid, move_dir,
    output game_status, board, blank_pos, move_cnt, move_err
  );
endinterface

// File: rtl/board_engine_tile_mover.sv
// Combinational blank-tile move: legality, swapped board and new blank index.
module tile_mover
  import game_pkg::*;
(
  input  logic [11:0] board,
  input  logic [1:0]  blank_pos,
  input  logic [1:0]  move_dir,
  output logic        legal,
  output logic [11:0] next_board,
  output logic [1:0]  next_blank
);

  logic [1:0] target;

  always_comb begin
    legal  = 1'b0;
    target = blank_pos;
    unique case (move_dir)
      DIR_UP:    begin legal =  blank_pos[1]; target = blank_pos - 2'd2; end
      DIR_DOWN:  begin legal = ~blank_pos[1]; target = blank_pos + 2'd2; end
      DIR_LEFT:  begin legal =  blank_pos[0]; target = blank_pos - 2'd1; end
      DIR_RIGHT: begin legal = ~blank_pos[0]; target = blank_pos + 2'd1; end
    endcase
  end

  // Full swap rather than writing a literal blank, so boards without a blank stay consistent.
  always_comb begin
    next_board = board;
    next_blank = blank_pos;
    if (legal) begin
      next_board = set_tile(set_tile(board, blank_pos, tile_at(board, target)),
                            target, tile_at(board, blank_pos));
      next_blank = target;
    end
  end

endmodule

// File: rtl/board_engine.sv
// Game-play engine: latches the chosen board, applies blank moves, counts them
// and drives the shared game_status bus.
module board_engine
  import game_pkg::*;
(
  input logic           clk_d,
  input logic           rst_n,
  board_engine_if.slave bus
);

  status_e     state, state_nx;
  logic [11:0] board_q, board_nx;
  logic [1:0]  blank_q, blank_nx;
  logic [9:0]  cnt_q, cnt_nx;
  logic        err_q, err_nx;

  logic        mv_legal;
  logic [11:0] mv_board;
  logic [1:0]  mv_blank;

  tile_mover u_mover (
    .board      (board_q),
    .blank_pos  (blank_q),
    .move_dir   (bus.move_dir),
    .legal      (mv_legal),
    .next_board (mv_board),
    .next_blank (mv_blank)
  );

  always_ff @(posedge clk_d) begin
    if (!rst_n) begin
      state   <= CHOSE_BOARD;
      board_q <= SOLVED_BOARD;
      blank_q <= 2'd0;
      cnt_q   <= 10'd0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      board_q <= board_nx;
      blank_q <= blank_nx;
      cnt_q   <= cnt_nx;
      err_q   <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    board_nx = board_q;
    blank_nx = blank_q;
    cnt_nx   = cnt_q;
    err_nx   = 1'b0;
    unique case (state)
      CHOSE_BOARD: begin
        // Sample board_in now: the generator forces identity once status leaves 00.
        if (bus.start) begin
          board_nx = bus.board_in;
          blank_nx = find_blank(bus.board_in);
          cnt_nx   = 10'd0;
          state_nx = GAME_INITIAL;
        end
      end
      GAME_INITIAL: begin
        state_nx = (board_q == SOLVED_BOARD) ? WINNED : GAMING;
      end
      GAMING: begin
        if (bus.give_up) begin
          state_nx = CHOSE_BOARD;
        end else if (bus.move_valid) begin
          if (mv_legal) begin
            board_nx = mv_board;
            blank_nx = mv_blank;
            if (cnt_q < MOVE_CNT_MAX) cnt_nx = cnt_q + 10'd1;
            if (mv_board == SOLVED_BOARD) state_nx = WINNED;
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      WINNED: begin
        if (bus.start) state_nx = CHOSE_BOARD;
      end
    endcase
  end

  assign bus.game_status = state;
  assign bus.board       = board_q;
  assign bus.blank_pos   = blank_q;
  assign bus.move_cnt    = cnt_q;
  assign bus.move_err    = err_q;

endmodule

// File: tb/tb_board_engine.sv
// Scoreboard bench for board_engine: stimulus queues the expected post-edge
// outputs each cycle, a monitor pops and compares them after every edge.
module tb_board_engine;

  typedef struct packed {
    logic [1:0]  st;
    logic [11:0] bd;
    logic [1:0]  bp;
    logic [9:0]  cnt;
    logic        err;
  } exp_t;

  logic clk_d = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk_d = ~clk_d;

  board_engine_if bus();

  board_engine dut (
    .clk_d (clk_d),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [1:0]  e_st;
  logic [11:0] e_bd;
  logic [1:0]  e_bp;
  logic [9:0]  e_cnt;

  // One clock of stimulus; e_* hold the outputs required after the coming edge.
  task automatic cyc(input logic r, input logic s, input logic g, input logic mv,
                     input logic [1:0] d, input logic [11:0] bin, input logic e_err);
    exp_t e;
    @(negedge clk_d);
    rst_n          = r;
    bus.start      = s;
    bus.give_up    = g;
    bus.move_valid = mv;
    bus.move_dir   = d;
    bus.board_in   = bin;
    e.st = e_st; e.bd = e_bd; e.bp = e_bp; e.cnt = e_cnt; e.err = e_err;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk_d);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if (bus.game_status !== e.st || bus.board !== e.bd || bus.blank_pos !== e.bp ||
            bus.move_cnt !== e.cnt || bus.move_err !== e.err) begin
          n_fail++;
          $display("FAIL out_chk#%0d got st=%b bd=%h bp=%0d cnt=%0d err=%b want st=%b bd=%h bp=%0d cnt=%0d err=%b",
                   n_tests, bus.game_status, bus.board, bus.blank_pos, bus.move_cnt, bus.move_err,
                   e.st, e.bd, e.bp, e.cnt, e.err);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: run still active at %0t, required to have finished", $time);
    $fatal(1, "timeout");
  end

  initial begin : stim
    bus.start = 1'b0; bus.give_up = 1'b0; bus.move_valid = 1'b0;
    bus.move_dir = 2'b00; bus.board_in = 12'h000;

    // Reset and idle
    e_st = 2'b00; e_bd = 12'h053; e_bp = 2'd0; e_cnt = 10'd0;
    cyc(0, 0, 0, 0, 2'b00, 12'h000, 0);
    cyc(1, 0, 0, 0, 2'b00, 12'h000, 0);
    cyc(1, 0, 0, 1, 2'b10, 12'h000, 0);   // move ignored in CHOSE_BOARD

    // 1: load 001_000_010_011
    e_st = 2'b10; e_bd = 12'h213; e_bp = 2'd1; e_cnt = 10'd0;
    cyc(1, 1, 0, 0, 2'b00, 12'h213, 0);
    e_st = 2'b01;
    cyc(1, 0, 0, 0, 2'b00, 12'h000, 0);

    // 2: winning left move, then frozen in WINNED, then start
    e_st = 2'b11; e_bd = 12'h053; e_bp = 2'd0; e_cnt = 10'd1;
    cyc(1, 0, 0, 1, 2'b10, 12'h000, 0);
    cyc(1, 0, 0, 1, 2'b11, 12'h000, 0);
    cyc(1, 0, 1, 0, 2'b00, 12'h000, 0);
    e_st = 2'b00;
    cyc(1, 1, 0, 0, 2'b00, 12'h000, 0);

    // 3: load 000_001_011_010, illegal up, then right/down/up
    e_st = 2'b10; e_bd = 12'h05A; e_bp = 2'd0; e_cnt = 10'd0;
    cyc(1, 1, 0, 0, 2'b00, 12'h05A, 0);
    e_st = 2'b01;
    cyc(1, 0, 0, 0, 2'b00, 12'h000, 0);
    cyc(1, 0, 0, 1, 2'b00, 12'h000, 1);
    cyc(1, 0, 0, 0, 2'b00, 12'h000, 0);
    cyc(1, 0, 0, 1, 2'b10, 12'h000, 1);   // left from col 0
    e_bd = 12'h21A; e_bp = 2'd1; e_cnt = 10'd1;
    cyc(1, 0, 0, 1, 2'b11, 12'h000, 0);
    cyc(1, 1, 0, 0, 2'b00, 12'h000, 0);   // start ignored in GAMING
    e_bd = 12'h298; e_bp = 2'd3; e_cnt = 10'd2;
    cyc(1, 0, 0, 1, 2'b01, 12'h000, 0);
    e_bd = 12'h21A; e_bp = 2'd1; e_cnt = 10'd3;
    cyc(1, 0, 0, 1, 2'b00, 12'h000, 0);

    // 5: give_up wins over a coincident legal move
    e_st = 2'b00;
    cyc(1, 0, 1, 1, 2'b10, 12'h000, 0);
    cyc(1, 0, 0, 0, 2'b00, 12'h000, 0);

    // 4: already solved goes straight to WINNED
    e_st = 2'b10; e_bd = 12'h053; e_bp = 2'd0; e_cnt = 10'd0;
    cyc(1, 1, 0, 0, 2'b00, 12'h053, 0);
    e_st = 2'b11;
    cyc(1, 0, 0, 0, 2'b00, 12'h000, 0);
    e_st = 2'b00;
    cyc(1, 1, 0, 0, 2'b00, 12'h000, 0);

    // Board with no blank: blank_pos falls back to 0
    e_st = 2'b10; e_bd = 12'h29C; e_bp = 2'd0;
    cyc(1, 1, 0, 0, 2'b00, 12'h29C, 0);
    e_st = 2'b01;
    cyc(1, 0, 0, 0, 2'b00, 12'h000, 0);
    e_st = 2'b00;
    cyc(1, 0, 1, 0, 2'b00, 12'h000, 0);

    // 6: saturation with back-to-back right/left, then mid-game reset
    e_st = 2'b10; e_bd = 12'h05A; e_bp = 2'd0; e_cnt = 10'd0;
    cyc(1, 1, 0, 0, 2'b00, 12'h05A, 0);
    e_st = 2'b01;
    cyc(1, 0, 0, 0, 2'b00, 12'h000, 0);
    for (int i = 0; i < 1005; i++) begin
      e_bd  = (i % 2 == 0) ? 12'h21A : 12'h05A;
      e_bp  = (i % 2 == 0) ? 2'd1 : 2'd0;
      e_cnt = (i + 1 > 999) ? 10'd999 : 10'(i + 1);
      cyc(1, 0, 0, 1, (i % 2 == 0) ? 2'b11 : 2'b10, 12'h000, 0);
    end
    e_st = 2'b00; e_bd = 12'h053; e_bp = 2'd0; e_cnt = 10'd0;
    cyc(0, 1, 0, 1, 2'b11, 12'h000, 0);
    cyc(1, 0, 0, 0, 2'b00, 12'h000, 0);

    @(posedge clk_d);
    #3;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
